half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Registered, parameterizable bitwise half adder.
- Each lane i computes sum[i] = a[i] XOR b[i] and carry[i] = a[i] AND b[i].
- Results are captured on a qualified input strobe and presented one clock later with a valid flag.
- Used as a leaf arithmetic primitive inside larger adder and accumulator datapaths; WIDTH=1 gives the classic single-bit half adder.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1..64).
- CNT_W, 16, width of the optional carry-event counter (legal range 4..32).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a and b for capture this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  high for exactly one cycle per accepted input.
- sum  output  WIDTH  registered a XOR b, per lane.
- carry  output  WIDTH  registered a AND b, per lane.
- any_carry  output  1  registered OR-reduction of carry.
- carry_count  output  CNT_W  present only with HALF_ADDER_CARRY_CNT_EN.

Behaviour:
- Reset: rst=1 sampled at a rising clk edge forces the following to 0 on that edge:
  - out_valid, sum, carry, any_carry.
  - carry_count, when present.
- rst has priority over in_valid in the same cycle; a coincident input is discarded.
- Accept: at an edge with rst=0 and in_valid=1:
  - sum <= a ^ b
  - carry <= a & b
  - any_carry <= |(a & b)
  - out_valid <= 1
- Latency: exactly 1 cycle from the accepting edge. Throughput is one result per cycle; back-to-back in_valid is fully supported.
- Idle: at an edge with rst=0 and in_valid=0:
  - out_valid <= 0.
  - sum, carry and any_carry hold their last values.
- Lanes are fully independent; there is no carry propagation between lanes.
- Arithmetic identity per lane: {carry[i], sum[i]} = a[i] + b[i], range 0..2.
- a and b are ignored when in_valid=0; X on a or b while in_valid=0 must not disturb any output.
- No combinational path from any input to any output.
- No backpressure: the downstream consumer must sample the result on the cycle out_valid=1.

Optional Feature:
- Macro: HALF_ADDER_CARRY_CNT_EN.
- Defined:
  - Adds the carry_count output.
  - On each accepted input whose a & b is nonzero, carry_count increments by 1.
  - The count saturates at all-ones and never wraps.
  - The counter is cleared by rst and updates on the same edge as sum and carry.
- Undefined:
  - The carry_count port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1, a=1, b=1 -> out_valid=0, sum=0, carry=0, any_carry=0, carry_count=0 after each edge.
- Truth table (WIDTH=1): apply (a,b)=00, 01, 10, 11 on consecutive cycles with in_valid=1 -> one cycle later, in order:
  - sum/carry = 0/0, 1/0, 1/0, 0/1
  - out_valid=1 each cycle
  - any_carry = 0, 0, 0, 1
- Hold: after the (1,1) result, drop in_valid and drive a=0, b=0 for 3 cycles -> out_valid=0; sum=0, carry=1 held.
- Multi-lane (WIDTH=8): a=8'hF0, b=8'h3C, in_valid=1 -> next cycle sum=8'hCC, carry=8'h30, any_carry=1, out_valid=1.
- Mid-stream reset: issue a=1, b=1 with in_valid=1 in the same cycle rst=1 -> after the edge out_valid=0, carry=0; the next cycle behaves normally.
- Counter (macro defined, CNT_W=4): 20 back-to-back accepts with a=1, b=1 -> carry_count reaches 15 and stays at 15; interleaved a=1, b=0 accepts do not increment it.

Source files
------------

// File: rtl/half_adder.sv
// rtl/half_adder.sv - registered, parameterizable bitwise half adder
//
// Each of WIDTH independent lanes produces sum = a ^ b and carry = a & b.
// Results are captured when in_valid is high and presented one clock later.
//
// Optional build macro: HALF_ADDER_CARRY_CNT_EN adds a saturating
// carry-event counter on the carry_count output.
//
// Parameters:
//   WIDTH        number of independent lanes (1..64)
//   CNT_W        carry-event counter width (4..32), used only with the macro
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     qualifies a and b for capture on this edge
//   a, b         operands, one bit per lane
//   out_valid    one-cycle pulse per accepted input
//   sum          registered a ^ b
//   carry        registered a & b
//   any_carry    registered OR-reduction of carry
//   carry_count  saturating count of accepts with nonzero a & b (macro only)

module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             any_carry
`ifdef HALF_ADDER_CARRY_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_count
`endif
);

  logic [WIDTH-1:0] carry_next;

  assign carry_next = a & b;

  // Result registers: out_valid pulses per accept; data holds while idle so
  // operands are never looked at unless in_valid qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= '0;
      any_carry <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum       <= a ^ b;
        carry     <= carry_next;
        any_carry <= |carry_next;
      end
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  // Saturating event counter: stops at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_valid && (|carry_next) && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign carry_count = cnt;
`endif

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - randomized self-checking bench for half_adder

module tb_half_adder;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [0:0] a1, b1;
  logic [7:0] a8, b8;

  logic       ov1, any1;
  logic [0:0] sum1, car1;
  logic       ov8, any8;
  logic [7:0] sum8, car8;
`ifdef HALF_ADDER_CARRY_CNT_EN
  logic [3:0]  cnt1;
  logic [15:0] cnt8;
`endif

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 0;

  half_adder #(.WIDTH(1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov1), .sum(sum1), .carry(car1), .any_carry(any1)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_count(cnt1)
`endif
  );

  half_adder #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov8), .sum(sum8), .carry(car8), .any_carry(any8)
`ifdef HALF_ADDER_CARRY_CNT_EN
    , .carry_count(cnt8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-lane arithmetic: {carry,sum} of a lane is the integer a[i]+b[i].
  function automatic logic [127:0] lanes(input logic [63:0] x, input logic [63:0] y, input int w);
    logic [63:0] s, c;
    int t;
    s = '0;
    c = '0;
    for (int i = 0; i < w; i++) begin
      t = int'(x[i]) + int'(y[i]);
      s[i] = (t % 2) == 1;
      c[i] = t >= 2;
    end
    return {c, s};
  endfunction

  // Reference model state
  logic       m1_v, m1_any, m8_v, m8_any;
  logic [0:0] m1_s, m1_c;
  logic [7:0] m8_s, m8_c;
  int         m1_cnt, m8_cnt;

  always @(posedge clk) begin
    logic [127:0] r1, r8;
    r1 = lanes(64'(a1), 64'(b1), 1);
    r8 = lanes(64'(a8), 64'(b8), 8);
    if (rst) begin
      m1_v <= 0; m1_s <= 0; m1_c <= 0; m1_any <= 0; m1_cnt <= 0;
      m8_v <= 0; m8_s <= 0; m8_c <= 0; m8_any <= 0; m8_cnt <= 0;
    end else begin
      m1_v <= in_valid;
      m8_v <= in_valid;
      if (in_valid) begin
        m1_s <= r1[0];
        m1_c <= r1[64];
        m1_any <= r1[127:64] != 0;
        if (r1[127:64] != 0 && m1_cnt < 15) m1_cnt <= m1_cnt + 1;
        m8_s <= r8[7:0];
        m8_c <= r8[71:64];
        m8_any <= r8[127:64] != 0;
        if (r8[127:64] != 0 && m8_cnt < 65535) m8_cnt <= m8_cnt + 1;
      end
    end
  end

  // Every-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("u1_valid", 64'(ov1), 64'(m1_v));
      chk("u1_sum", 64'(sum1), 64'(m1_s));
      chk("u1_carry", 64'(car1), 64'(m1_c));
      chk("u1_any", 64'(any1), 64'(m1_any));
      chk("u8_valid", 64'(ov8), 64'(m8_v));
      chk("u8_sum", 64'(sum8), 64'(m8_s));
      chk("u8_carry", 64'(car8), 64'(m8_c));
      chk("u8_any", 64'(any8), 64'(m8_any));
`ifdef HALF_ADDER_CARRY_CNT_EN
      chk("u1_cnt", 64'(cnt1), 64'(m1_cnt));
      chk("u8_cnt", 64'(cnt8), 64'(m8_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit v, input logic x, input logic y,
                       input logic [7:0] x8, input logic [7:0] y8);
    rst = r; in_valid = v; a1 = x; b1 = y; a8 = x8; b8 = y8;
  endtask

  initial begin
    logic [3:0] tt_s, tt_c;
    tt_s = 4'b0110;
    tt_c = 4'b1000;
    drive(1, 1, 1, 1, 8'hFF, 8'hFF);

    // Reset held with live input
    for (int k = 0; k < 2; k++) begin
      step();
      armed = 1;
      chk("rst_valid", 64'(ov1), 0);
      chk("rst_sum", 64'(sum1), 0);
      chk("rst_carry", 64'(car1), 0);
      chk("rst_any", 64'(any8), 0);
`ifdef HALF_ADDER_CARRY_CNT_EN
      chk("rst_cnt", 64'(cnt1), 0);
`endif
    end

    // Truth table, back to back
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, k[1], k[0], 8'($urandom), 8'($urandom));
      step();
      chk("tt_valid", 64'(ov1), 1);
      chk("tt_sum", 64'(sum1), 64'(tt_s[k]));
      chk("tt_carry", 64'(car1), 64'(tt_c[k]));
      chk("tt_any", 64'(any1), 64'(tt_c[k]));
    end

    // Hold while idle
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("hold_valid", 64'(ov1), 0);
      chk("hold_sum", 64'(sum1), 0);
      chk("hold_carry", 64'(car1), 1);
    end

    // Multi-lane
    drive(0, 1, 0, 0, 8'hF0, 8'h3C);
    step();
    chk("ml_sum", 64'(sum8), 64'hCC);
    chk("ml_carry", 64'(car8), 64'h30);
    chk("ml_any", 64'(any8), 1);
    chk("ml_valid", 64'(ov8), 1);

    // Mid-stream reset discards a coincident input
    drive(1, 1, 1, 1, 8'hFF, 8'h0F);
    step();
    chk("msr_valid", 64'(ov1), 0);
    chk("msr_carry", 64'(car1), 0);
    chk("msr_carry8", 64'(car8), 0);
    drive(0, 1, 1, 0, 8'h01, 8'h01);
    step();
    chk("msr_next_valid", 64'(ov1), 1);
    chk("msr_next_sum", 64'(sum1), 1);
    chk("msr_next_carry8", 64'(car8), 64'h01);

    // Saturating counter: 20 carry accepts interleaved with no-carry accepts
    drive(1, 0, 0, 0, 8'h00, 8'h00);
    step();
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, 1, 1, 8'h80, 8'h80);
      step();
      drive(0, 1, 1, 0, 8'h80, 8'h00);
      step();
    end
`ifdef HALF_ADDER_CARRY_CNT_EN
    chk("cnt_sat", 64'(cnt1), 15);
    chk("cnt_wide", 64'(cnt8), 20);
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
      step();
    end

    drive(0, 0, 0, 0, 8'h00, 8'h00);
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
